// File: rtl/result_compare_pkg.sv
// Shared types and constants for the result comparator.
//   cmp_state_t    : controller states
//   EOT_TAG        : tag value marking the end-of-test result word
//   RES_* / EXP_*  : bit positions of the fields inside the result and expected words
//   result_word_t  : {tag, MISO data} as popped from the result FIFO
//   expect_word_t  : {mask, expected value} as popped from the expected FIFO
//   vec_mismatch() : masked compare of one result/expected pair
package result_compare_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        POP,
        CMP,
        DONE
    } cmp_state_t;

    localparam logic [5:0] EOT_TAG = 6'h3F;

    // Result word: [29:24] tag, [23:0] data
    localparam int unsigned RES_DATA_LSB = 0;
    localparam int unsigned RES_DATA_MSB = 23;
    localparam int unsigned RES_TAG_LSB  = 24;
    localparam int unsigned RES_TAG_MSB  = 29;

    // Expected word: [47:24] mask, [23:0] expected value
    localparam int unsigned EXP_VAL_LSB  = 0;
    localparam int unsigned EXP_VAL_MSB  = 23;
    localparam int unsigned EXP_MASK_LSB = 24;
    localparam int unsigned EXP_MASK_MSB = 47;

    typedef struct packed {
        logic [RES_TAG_MSB-RES_TAG_LSB:0]   tag;
        logic [RES_DATA_MSB-RES_DATA_LSB:0] data;
    } result_word_t;

    typedef struct packed {
        logic [EXP_MASK_MSB-EXP_MASK_LSB:0] mask;
        logic [EXP_VAL_MSB-EXP_VAL_LSB:0]   value;
    } expect_word_t;

    // Only bits with mask=1 take part; an all-zero mask always matches.
    function automatic logic vec_mismatch(input result_word_t r, input expect_word_t e);
        return |((r.data ^ e.value) & e.mask);
    endfunction

endpackage

// File: rtl/result_compare_sat_counter.sv
// Saturating up-counter.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset, count -> 0
//   clear  : synchronous clear, count -> 0
//   inc    : increment by one unless already all-ones
//   count  : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/result_compare.sv
// Pairs result words with expected words from two normal-mode FIFOs, performs a masked
// compare per vector, keeps vector/error counts and the index of the first failing vector,
// and reports pass/fail once the end-of-test word (tag 6'h3F) is consumed.
//
// Optional build macro RESULT_COMPARE_STOP_ON_FAIL_EN: when defined, the first mismatch ends
// the run (done=1, pass=0) and no further words are popped.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   enable                : starts a run (sampled in IDLE only)
//   rfifo_dataq/rdreq/rdempty : result FIFO read side, word = {tag, data}
//   efifo_dataq/rdreq/rdempty : expected FIFO read side, word = {mask, expected}
//   vec_count, err_count  : vectors compared / mismatching vectors (saturating)
//   first_err_idx/valid   : 0-based index of the first mismatching vector
//   busy, done, pass      : run in progress / EOT processed / no mismatches seen
module result_compare
    import result_compare_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] rfifo_dataq,
    output logic                          rfifo_rdreq,
    input  logic                          rfifo_rdempty,
    input  logic [2*DATA_WIDTH-1:0]       efifo_dataq,
    output logic                          efifo_rdreq,
    input  logic                          efifo_rdempty,
    output logic [CNT_WIDTH-1:0]          vec_count,
    output logic [CNT_WIDTH-1:0]          err_count,
    output logic [CNT_WIDTH-1:0]          first_err_idx,
    output logic                          first_err_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          pass
);

    cmp_state_t state_q, state_d;

    result_word_t rword;
    expect_word_t eword;
    logic         mismatch;

    logic clear;
    logic vec_inc;
    logic err_inc;
    logic finish;
    logic pass_d;

    logic                 done_q;
    logic                 pass_q;
    logic                 first_err_valid_q;
    logic [CNT_WIDTH-1:0] first_err_idx_q;

    assign rword    = result_word_t'(rfifo_dataq);
    assign eword    = expect_word_t'(efifo_dataq);
    assign mismatch = vec_mismatch(rword, eword);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        vec_inc = 1'b0;
        err_inc = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    clear   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Both words must be available so the two pops never split.
                if (!rfifo_rdempty && !efifo_rdempty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = CMP;
            end
            CMP: begin
                if (rword.tag == EOT_TAG) begin
                    // The paired expected word is a dummy and is simply dropped.
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    vec_inc = 1'b1;
                    state_d = WAIT;
                    if (mismatch) begin
                        err_inc = 1'b1;
`ifdef RESULT_COMPARE_STOP_ON_FAIL_EN
                        finish  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A run ending on a mismatch (stop-on-fail) fails even though err_count has not updated yet.
    assign pass_d = (err_count == '0) && !err_inc;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            if (finish) begin
                done_q <= 1'b1;
                pass_q <= pass_d;
            end
            if (err_inc && !first_err_valid_q) begin
                first_err_idx_q   <= vec_count;
                first_err_valid_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_vec_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (vec_inc),
        .count (vec_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

    assign rfifo_rdreq     = (state_q == POP);
    assign efifo_rdreq     = (state_q == POP);
    assign busy            = (state_q == WAIT) || (state_q == POP) || (state_q == CMP);
    assign done            = done_q;
    assign pass            = pass_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule

// File: tb/tb_result_compare.sv
// Self-checking bench for result_compare: bench-side FIFO models, a scoreboard model of the
// counters/pass rules checked every cycle, and directed tests with literal expectations.
// A second instance with a 4-bit counter width exercises saturation.
module tb_result_compare;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, enable;
    logic [29:0] rfifo_dataq = '0;
    logic [47:0] efifo_dataq = '0;
    logic        rfifo_rdreq, rfifo_rdempty, efifo_rdreq, efifo_rdempty;
    logic [15:0] vec_count, err_count, first_err_idx;
    logic        first_err_valid, busy, done, pass;

    result_compare u_dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .rfifo_dataq     (rfifo_dataq),
        .rfifo_rdreq     (rfifo_rdreq),
        .rfifo_rdempty   (rfifo_rdempty),
        .efifo_dataq     (efifo_dataq),
        .efifo_rdreq     (efifo_rdreq),
        .efifo_rdempty   (efifo_rdempty),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid),
        .busy            (busy),
        .done            (done),
        .pass            (pass)
    );

    // Narrow instance: always-full FIFOs carrying a mismatching pair.
    logic        s_reset, s_enable, s_empty;
    logic [29:0] s_rdata;
    logic [47:0] s_edata;
    logic        s_rreq, s_ereq, s_valid, s_busy, s_done, s_pass;
    logic [3:0]  s_vec, s_err, s_idx;

    result_compare #(
        .CNT_WIDTH (4)
    ) u_small (
        .clock           (clock),
        .reset           (s_reset),
        .enable          (s_enable),
        .rfifo_dataq     (s_rdata),
        .rfifo_rdreq     (s_rreq),
        .rfifo_rdempty   (s_empty),
        .efifo_dataq     (s_edata),
        .efifo_rdreq     (s_ereq),
        .efifo_rdempty   (s_empty),
        .vec_count       (s_vec),
        .err_count       (s_err),
        .first_err_idx   (s_idx),
        .first_err_valid (s_valid),
        .busy            (s_busy),
        .done            (s_done),
        .pass            (s_pass)
    );

    // Normal-mode FIFO models: q updates on the edge after rdreq.
    logic [29:0] rmem [0:255];
    logic [47:0] emem [0:255];
    int rwr = 0, rrd = 0, ewr = 0, erd = 0;
    int rpops = 0, epops = 0;

    assign rfifo_rdempty = (rwr == rrd);
    assign efifo_rdempty = (ewr == erd);

    always @(posedge clock) begin
        if (rfifo_rdreq && (rwr != rrd)) begin
            rfifo_dataq <= rmem[rrd[7:0]];
            rrd         <= rrd + 1;
        end
        if (efifo_rdreq && (ewr != erd)) begin
            efifo_dataq <= emem[erd[7:0]];
            erd         <= erd + 1;
        end
        if (rfifo_rdreq) rpops <= rpops + 1;
        if (efifo_rdreq) epops <= epops + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: results implied by every pair popped since the last run start.
    int m_vec, m_err, m_first;
    bit m_fvalid;

    task automatic model_clear();
        m_vec    = 0;
        m_err    = 0;
        m_first  = 0;
        m_fvalid = 0;
    endtask

    task automatic model_consume(input logic [29:0] r, input logic [47:0] e);
        if (r[29:24] != 6'h3F) begin
            if (((r[23:0] ^ e[23:0]) & e[47:24]) != 24'h0) begin
                if (!m_fvalid) begin
                    m_first  = m_vec;
                    m_fvalid = 1;
                end
                if (m_err < 65535) m_err = m_err + 1;
            end
            if (m_vec < 65535) m_vec = m_vec + 1;
        end
    endtask

    initial begin : compare_proc
        logic busy_prev;
        busy_prev = 1'b0;
        model_clear();
        forever begin
            @(negedge clock);
            if (busy === 1'b1 && busy_prev !== 1'b1) model_clear();
            busy_prev = busy;
            check("pop_pair", 48'(rfifo_rdreq), 48'(efifo_rdreq));
            if (rfifo_rdreq === 1'b1) begin
                check("pop_nonempty", 48'(rfifo_rdempty | efifo_rdempty), 48'(0));
                check("vec_at_pop", 48'(vec_count), 48'(m_vec));
                check("err_at_pop", 48'(err_count), 48'(m_err));
                model_consume(rmem[rrd[7:0]], emem[erd[7:0]]);
            end
            if (done === 1'b1) begin
                check("done_vec", 48'(vec_count), 48'(m_vec));
                check("done_err", 48'(err_count), 48'(m_err));
                check("done_pass", 48'(pass), 48'(m_err == 0));
                check("done_fvalid", 48'(first_err_valid), 48'(m_fvalid));
                if (m_fvalid) check("done_fidx", 48'(first_err_idx), 48'(m_first));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_r(input logic [5:0] tag, input logic [23:0] data);
        rmem[rwr[7:0]] = {tag, data};
        rwr = rwr + 1;
    endtask

    task automatic push_e(input logic [23:0] mask, input logic [23:0] exp);
        emem[ewr[7:0]] = {mask, exp};
        ewr = ewr + 1;
    endtask

    task automatic push_vec(input logic [5:0] tag, input logic [23:0] data,
                            input logic [23:0] exp, input logic [23:0] mask);
        push_r(tag, data);
        push_e(mask, exp);
    endtask

    task automatic push_eot();
        push_vec(6'h3F, 24'h0, 24'h0, 24'h0);
    endtask

    task automatic start_run();
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) break;
        end
        check(name, 48'(done), 48'(1));
    endtask

    task automatic check_results(input string name, input int vec, input int err, input bit ps);
        check({name, "_vec"}, 48'(vec_count), 48'(vec));
        check({name, "_err"}, 48'(err_count), 48'(err));
        check({name, "_pass"}, 48'(pass), 48'(ps));
    endtask

    initial begin : main
        int n;
        int rp0, ep0;
        reset    = 1'b1;
        enable   = 1'b0;
        s_reset  = 1'b1;
        s_enable = 1'b0;
        s_empty  = 1'b0;
        s_rdata  = {6'h00, 24'h000000};
        s_edata  = {24'hFFFFFF, 24'h000001};
        repeat (3) tick();
        @(negedge clock);
        check("rst_vec", 48'(vec_count), 48'(0));
        check("rst_err", 48'(err_count), 48'(0));
        check("rst_busy", 48'(busy), 48'(0));
        check("rst_done", 48'(done), 48'(0));
        check("rst_pass", 48'(pass), 48'(0));
        check("rst_fvalid", 48'(first_err_valid), 48'(0));
        check("rst_rdreq", 48'(rfifo_rdreq), 48'(0));
        tick();
        reset   = 1'b0;
        s_reset = 1'b0;

        // 1: three matching vectors then EOT
        for (int i = 0; i < 3; i++) push_vec(6'h00, 24'h100 + 24'(i), 24'h100 + 24'(i), 24'hFFFFFF);
        push_eot();
        start_run();
        wait_done("t1_done", 100);
        check_results("t1", 3, 0, 1'b1);
        check("t1_fvalid", 48'(first_err_valid), 48'(0));
        check("t1_busy", 48'(busy), 48'(0));

        // 2a: second of four vectors mismatches in bit 0
        tick();
        push_vec(6'h00, 24'h000010, 24'h000010, 24'hFFFFFF);
        push_vec(6'h00, 24'h000002, 24'h000003, 24'hFFFFFF);
        push_vec(6'h05, 24'h000007, 24'h000007, 24'hFFFFFF);
        push_vec(6'h00, 24'h000000, 24'h000000, 24'hFFFFFF);
        push_eot();
        start_run();
        wait_done("t2a_done", 100);
        check_results("t2a", 4, 1, 1'b0);
        check("t2a_fidx", 48'(first_err_idx), 48'(1));
        check("t2a_fvalid", 48'(first_err_valid), 48'(1));

        // 2b: bit 0 masked off; an all-zero mask and a non-EOT tag also match
        tick();
        push_vec(6'h00, 24'h000010, 24'h000010, 24'hFFFFFF);
        push_vec(6'h00, 24'h000002, 24'h000003, 24'hFFFFFE);
        push_vec(6'h3E, 24'h000007, 24'h000007, 24'hFFFFFF);
        push_vec(6'h00, 24'hABCDEF, 24'h123456, 24'h000000);
        push_eot();
        start_run();
        wait_done("t2b_done", 100);
        check_results("t2b", 4, 0, 1'b1);
        check("t2b_fvalid", 48'(first_err_valid), 48'(0));

        // 3: result present, expected FIFO empty -> no pop until it fills
        tick();
        push_r(6'h00, 24'h000055);
        start_run();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("t3_nopop", 48'(rfifo_rdreq), 48'(0));
            check("t3_busy", 48'(busy), 48'(1));
        end
        tick();
        push_e(24'hFFFFFF, 24'h000055);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rfifo_rdreq === 1'b1) begin
                n = 1;
                break;
            end
        end
        check("t3_pop_seen", 48'(n), 48'(1));
        check("t3_pop_e", 48'(efifo_rdreq), 48'(1));
        @(negedge clock);
        check("t3_cmp_cycle_vec", 48'(vec_count), 48'(0));
        @(negedge clock);
        check("t3_after_cmp_vec", 48'(vec_count), 48'(1));
        push_eot();
        wait_done("t3_done", 100);
        check_results("t3", 1, 0, 1'b1);

        // 4: reset while in CMP, then restart on the remaining FIFO contents
        tick();
        push_vec(6'h00, 24'h000001, 24'h000001, 24'hFFFFFF);
        push_vec(6'h00, 24'h000002, 24'h000000, 24'hFFFFFF);
        push_vec(6'h00, 24'h000003, 24'h000003, 24'hFFFFFF);
        start_run();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rfifo_rdreq === 1'b1) n = n + 1;
            if (n == 2) break;
        end
        check("t4_two_pops", 48'(n), 48'(2));
        tick();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t4_rst_vec", 48'(vec_count), 48'(0));
        check("t4_rst_err", 48'(err_count), 48'(0));
        check("t4_rst_fvalid", 48'(first_err_valid), 48'(0));
        check("t4_rst_fidx", 48'(first_err_idx), 48'(0));
        check("t4_rst_busy", 48'(busy), 48'(0));
        check("t4_rst_done", 48'(done), 48'(0));
        check("t4_rst_pass", 48'(pass), 48'(0));
        check("t4_rst_rdreq", 48'(rfifo_rdreq), 48'(0));
        tick();
        reset = 1'b0;
        start_run();
        @(negedge clock);
        check("t4_restart_vec", 48'(vec_count), 48'(0));
        check("t4_restart_busy", 48'(busy), 48'(1));
        push_eot();
        wait_done("t4_done", 100);
        check_results("t4", 1, 0, 1'b1);

        // 5: saturation on the 4-bit instance, every vector mismatches
        tick();
        s_enable = 1'b1;
        tick();
        s_enable = 1'b0;
        repeat (90) @(negedge clock);
        check("t5_vec_sat", 48'(s_vec), 48'(15));
        check("t5_err_sat", 48'(s_err), 48'(15));
        check("t5_fidx", 48'(s_idx), 48'(0));
        check("t5_fvalid", 48'(s_valid), 48'(1));
        check("t5_busy", 48'(s_busy), 48'(1));
        repeat (30) @(negedge clock);
        check("t5_vec_nowrap", 48'(s_vec), 48'(15));
        check("t5_err_nowrap", 48'(s_err), 48'(15));
        tick();
        s_reset = 1'b1;

        // 6: mismatch at vector 0 of 5
        tick();
        rp0 = rpops;
        ep0 = epops;
        push_vec(6'h00, 24'h000001, 24'h000000, 24'hFFFFFF);
        for (int i = 0; i < 4; i++) push_vec(6'h00, 24'h20 + 24'(i), 24'h20 + 24'(i), 24'hFFFFFF);
        push_eot();
        start_run();
        wait_done("t6_done", 200);
        repeat (5) @(negedge clock);
        check("t6_fidx", 48'(first_err_idx), 48'(0));
`ifdef RESULT_COMPARE_STOP_ON_FAIL_EN
        check_results("t6", 1, 1, 1'b0);
        check("t6_rpops", 48'(rpops - rp0), 48'(1));
        check("t6_epops", 48'(epops - ep0), 48'(1));
`else
        check_results("t6", 5, 1, 1'b0);
        check("t6_rpops", 48'(rpops - rp0), 48'(6));
        check("t6_epops", 48'(epops - ep0), 48'(6));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_compare.md
Name: result_compare

Overview:
- Consumes the result FIFO that the DUT interface fills, and pairs each result word with an expected-value word from a second FIFO.
- Performs a masked compare per vector.
- Maintains vector and error counts and the index of the first failing vector.
- Flags pass/fail when the end-of-test marker arrives. Sits downstream of the DUT interface, on the read side of the result FIFO, in the DUT clock domain.

Parameters:
- DATA_WIDTH, 24, width of the MISO data field and of the expected/mask fields.
- TAG_WIDTH, 6, width of the tag field in a result word.
- CNT_WIDTH, 16, width of all counters and of the index output.

Ports:
- clock  in  1  block clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  starts a test run.
- rfifo_dataq  in  TAG_WIDTH+DATA_WIDTH (30)  result word: [29:24] tag, [23:0] MISO data.
- rfifo_rdreq  out  1  result FIFO pop.
- rfifo_rdempty  in  1  result FIFO empty.
- efifo_dataq  in  2*DATA_WIDTH (48)  expected word: [47:24] mask (1 = bit compared), [23:0] expected.
- efifo_rdreq  out  1  expected FIFO pop.
- efifo_rdempty  in  1  expected FIFO empty.
- vec_count  out  CNT_WIDTH  vectors compared (EOT not counted).
- err_count  out  CNT_WIDTH  mismatching vectors.
- first_err_idx  out  CNT_WIDTH  0-based index of the first mismatching vector.
- first_err_valid  out  1  first_err_idx holds a captured value.
- busy  out  1  run in progress.
- done  out  1  EOT processed.
- pass  out  1  valid while done: 1 = err_count is 0.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE. Reset mid-run aborts the run; FIFO contents are untouched.
- FIFOs are normal mode: q is valid the cycle after rdreq.
- States:
  - IDLE: on enable=1, clear the counters, first_err_*, done and pass; go to WAIT. busy=1 in every state except IDLE and DONE.
  - WAIT: if both rdempty=0, go to POP; otherwise stay.
  - POP: assert rfifo_rdreq and efifo_rdreq together for exactly one cycle; go to CMP.
  - CMP: sample both q values.
    - If tag == 6'h3F (EOT): discard the expected word and go to DONE.
    - Otherwise compute mismatch = |((rdata ^ exp) & mask); increment vec_count.
    - On mismatch: increment err_count; if first_err_valid=0, load first_err_idx with vec_count (pre-increment value) and set first_err_valid.
    - Go to WAIT.
  - DONE: done=1; pass = (err_count==0). Counters and outputs hold. When enable=0, return to IDLE; done and results stay visible until the next start.
- Pairing: exactly one expected word per result word, including a dummy expected word for EOT. The two pops never split.
- Throughput: at most one vector per 3 clocks. The rdreq pulses never occur while the corresponding rdempty=1.
- Counters saturate at all-ones (16'hFFFF); no wrap.
- A mask of all zeros is always a match.
- Tags other than 6'h3F are ignored for compare purposes.
- enable is ignored outside IDLE and DONE.

Optional Feature:
- Macro: RESULT_COMPARE_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CMP moves the block to DONE with pass=0. No further pops occur; the FIFOs keep their remaining entries.
- Undefined: the run always continues to EOT.
- Counters and first_err_* behave identically in both builds up to the stop point.

Decomposition:
- Package result_compare_pkg holds:
  - state enum cmp_state_t {IDLE, WAIT, POP, CMP, DONE};
  - localparam EOT_TAG = 6'h3F;
  - field-position localparams for the result and expected words;
  - packed struct typedefs result_word_t and expect_word_t.
- Sub-module sat_counter (parameterised width; clear, inc, saturate) is instantiated for vec_count and err_count.

Test Plan:
1. Three vectors with rdata == exp and mask=24'hFFFFFF, then EOT -> done=1, pass=1, vec_count=3, err_count=0, first_err_valid=0.
2. Vector 2 of 4 has rdata=24'h000002, exp=24'h000003, mask=24'hFFFFFF -> err_count=1, first_err_idx=1, pass=0; the same vector with mask=24'hFFFFFE -> pass=1.
3. rfifo has data but efifo is empty for 20 cycles -> no rdreq, busy=1; efifo write -> both pop in the same cycle, and compare follows 1 cycle later.
4. Assert reset while in CMP mid-run -> all outputs 0 and state IDLE next cycle; a new enable restarts with counters at 0.
5. Preload err_count path with 65537 mismatches -> err_count=16'hFFFF, vec_count=16'hFFFF, no wrap.
6. With RESULT_COMPARE_STOP_ON_FAIL_EN defined, mismatch at vector 0 of 5 -> done=1, pass=0, vec_count=1, and exactly 1 pop pulse observed on each FIFO.
